// File: rtl/lin_buff_ctrl_pkg.sv
// Shared constants for the line-buffer sequencer and the HOG blocks downstream of it.
// The kernel prime offset and per-frame kernel count are defined once here.
package lin_buff_ctrl_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Raster index of the first kernel's bottom-right pixel, counted from the first pixel fed.
    function automatic int unsigned prime_offset(
        input int unsigned img_w,
        input int unsigned blk_w,
        input int unsigned blk_h
    );
        return (blk_h - 1) * img_w + (blk_w - 1);
    endfunction

    function automatic int unsigned valid_kernels(
        input int unsigned img_w,
        input int unsigned img_h,
        input int unsigned blk_w,
        input int unsigned blk_h
    );
        return (img_w - blk_w + 1) * (img_h - blk_h + 1);
    endfunction

endpackage

// File: rtl/lin_buff_ctrl_raster_cnt.sv
// Column/row raster position counter, wrapping modulo one frame.
// wrap flags that the current position is the last pixel of the frame.
module raster_cnt #(
    parameter int unsigned W       = 854,
    parameter int unsigned H       = 480,
    parameter int unsigned RST_COL = 0,
    parameter int unsigned RST_ROW = 0,
    localparam int unsigned CW     = $clog2(W),
    localparam int unsigned RW     = $clog2(H)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    output logic [CW-1:0] col,
    output logic [RW-1:0] row,
    output logic          wrap
);

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic          col_end;
    logic          row_end;

    assign col_end = (col_q == CW'(W - 1));
    assign row_end = (row_q == RW'(H - 1));

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (inc) begin
            if (col_end) begin
                col_d = '0;
                row_d = row_end ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q <= CW'(RST_COL);
            row_q <= RW'(RST_ROW);
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    assign col  = col_q;
    assign row  = row_q;
    assign wrap = col_end && row_end;

endmodule

// File: rtl/lin_buff_ctrl.sv
// Frame-level sequencer for lin_buff: gates pixels in from start-of-frame, tracks every
// emitted kernel's raster position, discards edge-wrapping kernels and tags the rest.
module lin_buff_ctrl
    import lin_buff_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned IMG_WIDTH    = 854,
    parameter int unsigned IMG_HEIGHT   = 480,
    parameter int unsigned BLOCK_WIDTH  = 3,
    parameter int unsigned BLOCK_HEIGHT = 3,
    parameter int unsigned COL_W        = $clog2(IMG_WIDTH),
    parameter int unsigned ROW_W        = $clog2(IMG_HEIGHT)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  src_valid,
    output logic                  src_ready,
    input  logic [DATA_WIDTH-1:0] src_pixel,
    input  logic                  src_sof,
    output logic                  p_valid,
    input  logic                  p_ready,
    output logic [DATA_WIDTH-1:0] pixel,
    input  logic                  k_valid,
    output logic                  k_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [COL_W-1:0]      out_x,
    output logic [ROW_W-1:0]      out_y,
    output logic                  out_first,
    output logic                  out_last,
    output logic                  frame_done,
    output logic                  sof_err,
    output logic                  busy
);

    localparam int unsigned PRIME     = prime_offset(IMG_WIDTH, BLOCK_WIDTH, BLOCK_HEIGHT);
    localparam int unsigned K_RST_COL = PRIME % IMG_WIDTH;
    localparam int unsigned K_RST_ROW = (PRIME / IMG_WIDTH) % IMG_HEIGHT;

    state_e state_q, state_d;
    logic   frame_done_q, frame_done_d;
    logic   sof_err_q, sof_err_d;
    logic   busy_q, busy_d;

    logic [COL_W-1:0] pix_col, k_col;
    logic [ROW_W-1:0] pix_row, k_row;
    logic             pix_wrap_unused;
    logic             k_wrap;
    logic             pix_hs;
    logic             k_hs;
    logic             out_hs;
    logic             drop;

    // Kernel whose bottom-right sits left of or above the first full window wraps an edge.
    assign drop   = (k_col < COL_W'(BLOCK_WIDTH - 1)) || (k_row < ROW_W'(BLOCK_HEIGHT - 1));
    assign pix_hs = p_valid && p_ready;
    assign k_hs   = k_valid && k_ready;
    assign out_hs = out_valid && out_ready;
    assign pixel  = src_pixel;

    raster_cnt #(
        .W       (IMG_WIDTH),
        .H       (IMG_HEIGHT),
        .RST_COL (0),
        .RST_ROW (0)
    ) u_pix_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (pix_hs),
        .col  (pix_col),
        .row  (pix_row),
        .wrap (pix_wrap_unused)
    );

    raster_cnt #(
        .W       (IMG_WIDTH),
        .H       (IMG_HEIGHT),
        .RST_COL (K_RST_COL),
        .RST_ROW (K_RST_ROW)
    ) u_k_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (k_hs),
        .col  (k_col),
        .row  (k_row),
        .wrap (k_wrap)
    );

    // Handshake steering; IDLE drains lin_buff and holds the sof beat for RUN to consume.
    always_comb begin
        state_d   = state_q;
        src_ready = 1'b1;
        p_valid   = 1'b0;
        k_ready   = 1'b1;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                src_ready = !(src_valid && src_sof);
                if (src_valid && src_sof) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                p_valid   = src_valid;
                src_ready = p_ready;
                k_ready   = drop ? 1'b1 : out_ready;
                out_valid = k_valid && !drop;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_d       = (state_d == RUN);
        frame_done_d = out_hs && out_last;
        sof_err_d    = sof_err_q;
        if (pix_hs && src_sof && ((pix_col != '0) || (pix_row != '0))) begin
            sof_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            sof_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            sof_err_q    <= sof_err_d;
        end
    end

    assign out_x      = k_col - COL_W'(BLOCK_WIDTH - 1);
    assign out_y      = k_row - ROW_W'(BLOCK_HEIGHT - 1);
    assign out_first  = (out_x == '0) && (out_y == '0);
    assign out_last   = k_wrap;
    assign frame_done = frame_done_q;
    assign sof_err    = sof_err_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_lin_buff_ctrl.sv
// Bench for lin_buff_ctrl on an 8x4 image with a 3x3 kernel; a behavioural lin_buff
// offers kernel n once pixel n+OFF is in, and a scoreboard checks every tagged kernel.
module tb_lin_buff_ctrl;

    localparam int unsigned DW    = 8;
    localparam int unsigned W     = 8;
    localparam int unsigned H     = 4;
    localparam int unsigned BW    = 3;
    localparam int unsigned BH    = 3;
    localparam int unsigned CW    = 3;
    localparam int unsigned RW    = 2;
    localparam int          OFF   = (BH - 1) * W + (BW - 1);
    localparam int          FRAME = W * H;

    logic          clk;
    logic          rst;
    logic          src_valid;
    logic          src_ready;
    logic [DW-1:0] src_pixel;
    logic          src_sof;
    logic          p_valid;
    logic          p_ready;
    logic [DW-1:0] pixel;
    logic          k_valid;
    logic          k_ready;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_x;
    logic [RW-1:0] out_y;
    logic          out_first;
    logic          out_last;
    logic          frame_done;
    logic          sof_err;
    logic          busy;

    lin_buff_ctrl #(
        .DATA_WIDTH   (DW),
        .IMG_WIDTH    (W),
        .IMG_HEIGHT   (H),
        .BLOCK_WIDTH  (BW),
        .BLOCK_HEIGHT (BH),
        .COL_W        (CW),
        .ROW_W        (RW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .src_valid  (src_valid),
        .src_ready  (src_ready),
        .src_pixel  (src_pixel),
        .src_sof    (src_sof),
        .p_valid    (p_valid),
        .p_ready    (p_ready),
        .pixel      (pixel),
        .k_valid    (k_valid),
        .k_ready    (k_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_x      (out_x),
        .out_y      (out_y),
        .out_first  (out_first),
        .out_last   (out_last),
        .frame_done (frame_done),
        .sof_err    (sof_err),
        .busy       (busy)
    );

    typedef struct {
        int x;
        int y;
        bit first;
        bit last;
    } kern_t;

    kern_t sb[$];
    int    total = 0;
    int    bad = 0;
    int    pix_acc;
    int    k_acc;
    int    out_cnt;
    bit    run_exp;
    bit    last_prev;
    bit    sof_err_exp;
    bit    rand_mode;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // One clock: drive lin_buff model, sample mid-cycle, update model, advance to next negedge.
    task automatic tick(output bit acc);
        int  f;
        bit  drop_exp;
        kern_t e;
        if (rand_mode) begin
            out_ready = 1'($urandom_range(0, 1));
            p_ready   = ($urandom_range(0, 3) != 0);
        end else begin
            out_ready = 1'b1;
            p_ready   = 1'b1;
        end
        k_valid = (pix_acc > k_acc + OFF);
        #1;
        acc = src_valid && src_ready;
        chk("busy", 32'(busy), 32'(run_exp));
        chk("frame_done", 32'(frame_done), 32'(last_prev));
        chk("sof_err", 32'(sof_err), 32'(sof_err_exp));
        if (!run_exp) begin
            chk("idle_p_valid", 32'(p_valid), 0);
            chk("idle_k_ready", 32'(k_ready), 1);
            chk("idle_out_valid", 32'(out_valid), 0);
            chk("idle_src_ready", 32'(src_ready), 32'(!(src_valid && src_sof)));
        end else begin
            chk("src_ready", 32'(src_ready), 32'(p_ready));
            chk("p_valid", 32'(p_valid), 32'(src_valid));
            if (k_valid) begin
                f = (k_acc + OFF) % FRAME;
                drop_exp = ((f % W) < (BW - 1)) || ((f / W) < (BH - 1));
                chk("out_valid", 32'(out_valid), 32'(!drop_exp));
                chk("k_ready", 32'(k_ready), drop_exp ? 32'd1 : 32'(out_ready));
            end
        end
        if (p_valid) chk("pixel", 32'(pixel), 32'(src_pixel));
        if (out_valid && !out_ready) chk("stall_k_ready", 32'(k_ready), 0);
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("sb_empty", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("out_x", 32'(out_x), e.x);
                chk("out_y", 32'(out_y), e.y);
                chk("out_first", 32'(out_first), 32'(e.first));
                chk("out_last", 32'(out_last), 32'(e.last));
            end
            out_cnt++;
        end
        last_prev = out_valid && out_ready && out_last;
        if (p_valid && p_ready) begin
            if (src_sof && ((pix_acc % FRAME) != 0)) sof_err_exp = 1'b1;
            pix_acc++;
        end
        if (k_valid && k_ready) k_acc++;
        if (!run_exp && src_valid && src_sof) run_exp = 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_pixel(input bit sof);
        bit acc;
        int n;
        src_valid = 1'b1;
        src_sof   = sof;
        src_pixel = DW'($urandom);
        n = 0;
        acc = 1'b0;
        while (!acc && n < 200) begin
            tick(acc);
            n++;
        end
        if (!acc) chk("src_timeout", 0, 1);
        src_valid = 1'b0;
        src_sof   = 1'b0;
    endtask

    task automatic send_frame(input int npix, input int sof_extra);
        bit dummy;
        for (int y = 0; y <= H - BH; y++) begin
            for (int x = 0; x <= W - BW; x++) begin
                sb.push_back('{x, y, (x == 0 && y == 0), (x == W - BW && y == H - BH)});
            end
        end
        for (int i = 0; i < npix; i++) begin
            if (rand_mode) begin
                while ($urandom_range(0, 2) == 0) tick(dummy);
            end
            if (i == sof_extra) chk("sof_err_pre", 32'(sof_err), 0);
            send_pixel(i == 0 || i == sof_extra);
            if (i == sof_extra) chk("sof_err_rise", 32'(sof_err), 1);
        end
    endtask

    task automatic drain();
        bit dummy;
        int n;
        n = 0;
        while ((pix_acc > k_acc + OFF) && n < 2000) begin
            tick(dummy);
            n++;
        end
        if (n >= 2000) chk("drain_timeout", 0, 1);
        tick(dummy);
        tick(dummy);
        chk("drain_sb_empty", 32'(sb.size()), 0);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        src_valid = 1'b1;
        src_sof   = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_sof_err", 32'(sof_err), 0);
        chk("rst_frame_done", 32'(frame_done), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_p_valid", 32'(p_valid), 0);
        chk("rst_k_ready", 32'(k_ready), 1);
        chk("rst_out_x", 32'(out_x), 0);
        chk("rst_out_y", 32'(out_y), 0);
        src_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst         = 1'b0;
        pix_acc     = 0;
        k_acc       = 0;
        run_exp     = 1'b0;
        last_prev   = 1'b0;
        sof_err_exp = 1'b0;
        k_valid     = 1'b0;
        sb.delete();
    endtask

    initial begin
        rst       = 1'b0;
        src_valid = 1'b0;
        src_sof   = 1'b0;
        src_pixel = '0;
        p_ready   = 1'b1;
        k_valid   = 1'b0;
        out_ready = 1'b1;
        rand_mode = 1'b0;
        out_cnt   = 0;
        @(negedge clk);
        do_reset();

        // single frame, then a back-to-back second frame
        send_frame(FRAME, -1);
        drain();
        chk("t1_beats", 32'(out_cnt), 12);
        send_frame(FRAME, -1);
        drain();
        chk("t3_beats", 32'(out_cnt), 24);
        chk("t3_sof_err", 32'(sof_err), 0);

        // stray sof mid-frame
        send_frame(FRAME, 5);
        drain();
        chk("t5_beats", 32'(out_cnt), 36);
        chk("t5_sof_hold", 32'(sof_err), 1);

        // reset mid-frame, then a clean frame
        send_frame(17, -1);
        do_reset();
        out_cnt = 0;
        send_frame(FRAME, -1);
        drain();
        chk("t6_beats", 32'(out_cnt), 12);

        // pixels before sof are dropped
        do_reset();
        out_cnt = 0;
        for (int i = 0; i < 3; i++) send_pixel(1'b0);
        chk("t2_no_pix", 32'(pix_acc), 0);
        send_frame(FRAME, -1);
        drain();
        chk("t2_beats", 32'(out_cnt), 12);

        // random backpressure and source gaps
        out_cnt   = 0;
        rand_mode = 1'b1;
        send_frame(FRAME, -1);
        drain();
        rand_mode = 1'b0;
        chk("t4_beats", 32'(out_cnt), 12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lin_buff_ctrl.md
Name: lin_buff_ctrl

Overview:
Frame-level sequencer for the line buffer (lin_buff) in the HOG front end.
- Gates the raster pixel stream into lin_buff, aligned to start-of-frame.
- Tracks the raster position of every kernel that lin_buff emits.
- Consumes and discards kernels that wrap across a line edge or straddle two frames, so lin_buff never needs to be flushed between frames.
- Tags each surviving kernel with its window coordinates and first/last flags. Kernel data bypasses this block and goes from lin_buff straight to the consumer.

Parameters:
DATA_WIDTH, 8, pixel width in bits (equals lin_buff BUFFER_WIDTH)
IMG_WIDTH, 854, pixels per line (equals lin_buff BUFFER_DEPTH)
IMG_HEIGHT, 480, lines per frame
BLOCK_WIDTH, 3, kernel columns
BLOCK_HEIGHT, 3, kernel rows
COL_W, $clog2(IMG_WIDTH), column counter width
ROW_W, $clog2(IMG_HEIGHT), row counter width

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
src_valid  in  1  source pixel valid
src_ready  out  1  source pixel ready
src_pixel  in  DATA_WIDTH  source pixel
src_sof  in  1  marks the first pixel of a frame; qualified by src_valid
p_valid  out  1  pixel valid to lin_buff
p_ready  in  1  pixel ready from lin_buff
pixel  out  DATA_WIDTH  pixel to lin_buff (wire copy of src_pixel)
k_valid  in  1  kernel valid from lin_buff
k_ready  out  1  kernel ready to lin_buff
out_valid  out  1  qualified kernel valid to consumer
out_ready  in  1  consumer ready
out_x  out  COL_W  window left column
out_y  out  ROW_W  window top row
out_first  out  1  first valid kernel of the frame
out_last  out  1  last valid kernel of the frame
frame_done  out  1  one-cycle pulse registered after the out_last handshake
sof_err  out  1  sticky: src_sof seen off the frame origin
busy  out  1  state is RUN

Behaviour:
- One clock, clk. rst is asynchronous and active-high. All registers clear on rst.
- Reset values: state IDLE; pix_col, pix_row = 0; k_col = BLOCK_WIDTH-1; k_row = BLOCK_HEIGHT-1; frame_done, sof_err, busy = 0.
- IDLE state:
  - src_ready = 1, p_valid = 0: pixels without src_sof are dropped.
  - k_ready = 1, out_valid = 0: lin_buff is drained.
  - A src_valid && src_sof beat is not consumed in IDLE (src_ready = 0 for that beat). The next cycle the state is RUN.
- RUN state:
  - p_valid = src_valid; src_ready = p_ready. Both are combinational, with zero latency.
  - A pixel handshake (p_valid && p_ready) advances pix_col. pix_col wraps at IMG_WIDTH-1 and then increments pix_row; pix_row wraps at IMG_HEIGHT-1 to 0.
  - If a handshake carries src_sof while (pix_col, pix_row) != (0, 0), set sof_err. Counters are not realigned. sof_err clears only on rst.
- Kernel contract with lin_buff: the n-th kernel handshake after reset has its bottom-right pixel at raster index n + (BLOCK_HEIGHT-1)*IMG_WIDTH + (BLOCK_WIDTH-1). This index is counted continuously across frames.
- Kernel position tracking:
  - k_col and k_row track that bottom-right pixel.
  - They advance on every k_valid && k_ready, with the same wrap rules as the pixel counters (modulo the frame).
- drop = (k_col < BLOCK_WIDTH-1) || (k_row < BLOCK_HEIGHT-1).
- In RUN:
  - k_ready = drop ? 1 : out_ready.
  - out_valid = k_valid && !drop.
- Kernel coordinates:
  - out_x = k_col-(BLOCK_WIDTH-1).
  - out_y = k_row-(BLOCK_HEIGHT-1).
- Frame flags:
  - out_first = (out_x == 0 && out_y == 0).
  - out_last = (k_col == IMG_WIDTH-1 && k_row == IMG_HEIGHT-1).
  - Both are valid only with out_valid.
- Valid kernels per frame = (IMG_WIDTH-BLOCK_WIDTH+1)*(IMG_HEIGHT-BLOCK_HEIGHT+1).
- frame_done is registered and pulses for exactly one cycle after the out_valid && out_ready && out_last handshake.
- Backpressure: while out_ready = 0 on a non-dropped kernel, k_ready = 0 and the kernel counters hold. Backpressure reaches the source only through lin_buff p_ready.
- Simultaneous events: pixel and kernel handshakes in the same cycle update their counters independently.
- There is no return to IDLE except through rst.
- A mid-frame rst clears all state. lin_buff is reset by the same rst.

Decomposition:
- Shared package: state constants IDLE=0 and RUN=1; the prime-offset and valid-kernel-count expressions. Keep these in one place so lin_buff and downstream HOG blocks use the same values.
- One sub-module, raster_cnt (parameters W and H; inputs inc; outputs col, row, wrap). It is instantiated twice: once for pixel counting and once for kernel counting. The kernel instance has a reset column/row parameter.

Test Plan:
1. IMG 8x4, 3x3 kernel. One frame of 32 pixels with src_sof on pixel 0, out_ready = 1. Expect exactly 12 out_valid beats with (out_x, out_y) running (0,0)..(5,0) then (0,1)..(5,1). out_first on beat 1, out_last on beat 12, frame_done one cycle after beat 12.
2. Three pixels without sof, then an sof frame. The first 3 beats are accepted with p_valid = 0. The kernel sequence is identical to test 1.
3. Two back-to-back frames. The 2nd frame's first valid kernel is (0,0) with out_first. No kernel straddling the two frames reaches out_valid. 24 valid beats total.
4. Random out_ready (50%) and random src_valid gaps. Same 12 kernels, in order, each with correct coordinates. k_ready is held low while a non-dropped kernel is stalled.
5. src_sof asserted on pixel index 5 of frame 2. sof_err rises the cycle after that handshake and stays high. The kernel sequence is unchanged.
6. rst asserted mid-frame at pixel 17. All outputs return to reset values immediately. A new sof frame then produces the test-1 sequence.
